// File: rtl/add_constant_scheduler.sv
// Round-robin scheduler sharing one two-stage add-constant datapath among N requesters,
// each owning a private W-bit accumulator context.
module add_constant_scheduler #(
    parameter int             N    = 4,
    parameter int             W    = 32,
    parameter logic [W-1:0]   INCR = W'(2),
    parameter logic [W-1:0]   INIT = W'(0)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N-1:0]          req,
    input  logic [N-1:0]          init,
    output logic [N-1:0]          gnt,
    output logic                  rsp_vld,
    output logic [$clog2(N)-1:0]  rsp_id,
    output logic [W-1:0]          rsp_y,
    output logic                  busy
);

    localparam int IDW = $clog2(N);

    logic [W-1:0]   ctx_r [N];
    logic [IDW-1:0] rr_ptr_r;
    logic           s1_vld_r;
    logic           s1_init_r;
    logic [IDW-1:0] s1_id_r;

    logic [N-1:0]   elig_s;
    logic [N-1:0]   gnt_s;
    logic           found_s;
    logic           take_s;
    logic [IDW-1:0] gnt_id_s;
    logic [IDW-1:0] cand_s;
    logic [IDW-1:0] ptr_nxt_s;
    logic [W-1:0]   nxt_s;

    // Eligibility masking and first-eligible search starting at rr_ptr
    always_comb begin
        elig_s   = '0;
        gnt_s    = '0;
        found_s  = 1'b0;
        take_s   = 1'b0;
        gnt_id_s = '0;
        cand_s   = '0;
        for (int i = 0; i < N; i++) begin
            // An id still sitting in S1 has not written its context back yet.
            elig_s[i] = req[i] & en & rst & ~(s1_vld_r & (s1_id_r == IDW'(i)));
        end
        for (int off = 0; off < N; off++) begin
            if (int'(rr_ptr_r) + off >= N) begin
                cand_s = IDW'(int'(rr_ptr_r) + off - N);
            end else begin
                cand_s = IDW'(int'(rr_ptr_r) + off);
            end
            take_s   = ~found_s & elig_s[cand_s];
            gnt_id_s = take_s ? cand_s : gnt_id_s;
            found_s  = found_s | take_s;
        end
        if (found_s) begin
            gnt_s[gnt_id_s] = 1'b1;
        end else begin
            gnt_s = '0;
        end
    end

    // Next pointer after a grant and S1 compute value
    always_comb begin
        ptr_nxt_s = '0;
        nxt_s     = '0;
        if (gnt_id_s == IDW'(N - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = gnt_id_s + IDW'(1);
        end
        if (s1_init_r) begin
            nxt_s = INIT;
        end else begin
            nxt_s = ctx_r[s1_id_r] + INCR;
        end
    end

    assign gnt  = gnt_s;
    assign busy = s1_vld_r | rsp_vld;

    // Arbitration pointer, pipeline stages, context write-back and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                ctx_r[i] <= INIT;
            end
            rr_ptr_r  <= '0;
            s1_vld_r  <= 1'b0;
            s1_init_r <= 1'b0;
            s1_id_r   <= '0;
            rsp_vld   <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= '0;
        end else begin
            if (found_s) begin
                rr_ptr_r  <= ptr_nxt_s;
                s1_id_r   <= gnt_id_s;
                s1_init_r <= init[gnt_id_s];
            end else begin
                rr_ptr_r  <= rr_ptr_r;
                s1_id_r   <= s1_id_r;
                s1_init_r <= s1_init_r;
            end
            s1_vld_r <= found_s;
            rsp_vld  <= s1_vld_r;
            if (s1_vld_r) begin
                ctx_r[s1_id_r] <= nxt_s;
                rsp_id         <= s1_id_r;
                rsp_y          <= nxt_s;
            end else begin
                rsp_id <= rsp_id;
                rsp_y  <= rsp_y;
            end
        end
    end

endmodule

// File: tb/tb_add_constant_scheduler.sv
// Scoreboard bench: a behavioural arbitration/context model predicts grants and responses,
// a monitor pops expected responses whenever rsp_vld is seen.
module tb_add_constant_scheduler;

    localparam int N  = 4;
    localparam int TW = 4;
    localparam logic [TW-1:0] T_INCR = 4'd2;
    localparam logic [TW-1:0] T_INIT = 4'd0;

    logic          clk;
    logic          rst;
    logic          en;
    logic [N-1:0]  req;
    logic [N-1:0]  init;
    logic [N-1:0]  gnt;
    logic          rsp_vld;
    logic [1:0]    rsp_id;
    logic [TW-1:0] rsp_y;
    logic          busy;

    add_constant_scheduler #(.N(N), .W(TW), .INCR(T_INCR), .INIT(T_INIT)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .init(init), .gnt(gnt),
        .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy)
    );

    typedef struct {
        int            id;
        logic [TW-1:0] y;
        int            due;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // model state
    logic [TW-1:0] m_ctx [N];
    int            m_ptr;
    logic          m_s1_v, m_s2_v;
    int            m_s1_id;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_ctx[i] = T_INIT;
        m_ptr   = 0;
        m_s1_v  = 1'b0;
        m_s2_v  = 1'b0;
        m_s1_id = 0;
        sb_q.delete();
    endtask

    // One clock cycle: drive, predict the grant from the rotation rules, compare, advance model
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] it, input logic e,
                        output logic [N-1:0] g_seen);
        int   k;
        logic f;
        logic [N-1:0] exp_g;
        exp_t ex;
        req = r; init = it; en = e;
        @(negedge clk);
        f = 1'b0; k = 0; exp_g = '0;
        for (int off = 0; off < N; off++) begin
            int c;
            c = (m_ptr + off) % N;
            if (!f && r[c] && e && !(m_s1_v && m_s1_id == c)) begin
                f = 1'b1;
                k = c;
            end
        end
        if (f) exp_g[k] = 1'b1;
        chk("gnt", 32'(gnt), 32'(exp_g));
        chk("busy", 32'(busy), 32'(m_s1_v | m_s2_v));
        g_seen = gnt;
        if (f) begin
            m_ctx[k] = it[k] ? T_INIT : m_ctx[k] + T_INCR;
            ex.id  = k;
            ex.y   = m_ctx[k];
            ex.due = cyc + 2;
            sb_q.push_back(ex);
            m_ptr = (k + 1) % N;
        end
        m_s2_v  = m_s1_v;
        m_s1_v  = f;
        m_s1_id = k;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic [N-1:0] g;
        for (int i = 0; i < n; i++) step(4'b0000, 4'b0000, 1'b1, g);
    endtask

    // Response monitor: every rsp_vld pops one expected response
    always @(negedge clk) begin
        if (rst) begin
            if (rsp_vld) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected: got id=%0d y=%0d expected none (cycle %0d)", rsp_id, rsp_y, cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (int'(rsp_id) != e.id || rsp_y !== e.y || cyc != e.due) begin
                        bad++;
                        $display("FAIL rsp: got id=%0d y=%0d cyc=%0d expected id=%0d y=%0d cyc=%0d",
                                 rsp_id, rsp_y, cyc, e.id, e.y, e.due);
                    end
                end
            end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
                total++;
                bad++;
                $display("FAIL rsp_missing: got none expected id=%0d y=%0d (cycle %0d)", sb_q[0].id, sb_q[0].y, cyc);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        logic [N-1:0] g;
        logic [N-1:0] pend, pinit;
        rst = 1'b0; en = 1'b0; req = '0; init = '0;
        model_reset();
        #2;
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("reset_rsp_y", 32'(rsp_y), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // single op on id0, then a second one -> y=2 then 4
        step(4'b0001, 4'b0000, 1'b1, g);
        idle(2);
        step(4'b0001, 4'b0000, 1'b1, g);
        idle(3);

        // all requesting: strict rotation
        for (int i = 0; i < 8; i++) step(4'b1111, 4'b0000, 1'b1, g);
        idle(3);

        // lone requester: alternate-cycle grants
        for (int i = 0; i < 8; i++) step(4'b0100, 4'b0000, 1'b1, g);
        idle(3);

        // id1 driven through the 4-bit wrap
        for (int i = 0; i < 18; i++) step(4'b0010, 4'b0000, 1'b1, g);
        idle(3);

        // id3: three adds, re-init, then an add
        for (int i = 0; i < 6; i++) step(4'b1000, 4'b0000, 1'b1, g);
        step(4'b1000, 4'b1000, 1'b1, g);
        step(4'b1000, 4'b0000, 1'b1, g);
        step(4'b1000, 4'b0000, 1'b1, g);
        idle(3);

        // en low: no grants, in-flight ops drain
        step(4'b1111, 4'b0000, 1'b1, g);
        for (int i = 0; i < 4; i++) step(4'b1111, 4'b0000, 1'b0, g);
        chk("busy_drained", 32'(busy), 32'd0);
        idle(2);

        // reset while id0 sits in S1
        step(4'b0001, 4'b0000, 1'b1, g);
        rst = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_y", 32'(rsp_y), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        step(4'b0001, 4'b0000, 1'b1, g);
        idle(3);

        // randomized requesters honouring hold-until-grant, with occasional withdrawal
        pend = '0; pinit = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    pend[i]  = ($urandom_range(0, 1) == 0);
                    pinit[i] = ($urandom_range(0, 7) == 0);
                end else if ($urandom_range(0, 31) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            step(pend, pinit, ($urandom_range(0, 7) != 0), g);
            pend = pend & ~g;
        end
        idle(4);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
